// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        SEND    = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

    localparam int         UART_DATA_W = 8;
    localparam logic [3:0] NBITS_MIN   = 4'd5;
    localparam logic [3:0] NBITS_MAX   = 4'd8;

    function automatic logic nbits_legal(input logic [3:0] nbits);
        return (nbits >= NBITS_MIN) && (nbits <= NBITS_MAX);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above ptr_i, wrapping.
module rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDW-1:0]     idx_o
);

    logic found_s;

    // Scan NUM_REQ candidates starting at the pointer; the first hit wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found_s = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            logic [IDW:0]   sum;
            logic [IDW-1:0] cand;
            logic           hit;
            sum  = {1'b0, ptr_i} + (IDW+1)'(k);
            cand = (sum >= (IDW+1)'(NUM_REQ)) ? IDW'(sum - (IDW+1)'(NUM_REQ)) : IDW'(sum);
            hit  = !found_s && req_valid_i[cand];
            grant_o[cand] = hit;
            idx_o   = hit ? cand : idx_o;
            found_s = found_s | hit;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the shared UART transmitter, with a Tick-based watchdog
// that aborts frames the transmitter never completes.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int TIMEOUT_TICKS = 192,
    parameter int DEF_NBITS     = 8
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic [NUM_REQ-1:0]             ReqValid,
    input  logic [NUM_REQ*UART_DATA_W-1:0] ReqData,
    output logic [NUM_REQ-1:0]             ReqReady,
    input  logic [3:0]                     CfgNBits,
    input  logic                           Tick,
    input  logic                           TxDone,
    output logic                           TxEn,
    output logic [UART_DATA_W-1:0]         TxData,
    output logic [3:0]                     NBits,
    output logic                           Busy,
    output logic [$clog2(NUM_REQ)-1:0]     GrantId,
    output logic                           TimeoutErr
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int WDW = $clog2(TIMEOUT_TICKS);

    arb_state_e             state_q;
    logic [NUM_REQ-1:0]     req_ready_q;
    logic                   tx_en_q;
    logic [UART_DATA_W-1:0] tx_data_q;
    logic [3:0]             nbits_q;
    logic                   busy_q;
    logic [IDW-1:0]         grant_id_q;
    logic                   timeout_err_q;
    logic [IDW-1:0]         ptr_q;
    logic [WDW-1:0]         wdog_q;

    logic [NUM_REQ-1:0]     pick_grant_s;
    logic [IDW-1:0]         pick_idx_s;
    logic [3:0]             nbits_s;
    logic [IDW-1:0]         ptr_next_s;
    logic [UART_DATA_W-1:0] req_bytes_s [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign req_bytes_s[g] = ReqData[g*UART_DATA_W +: UART_DATA_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req_valid_i (ReqValid),
        .ptr_i       (ptr_q),
        .grant_o     (pick_grant_s),
        .idx_o       (pick_idx_s)
    );

    assign nbits_s    = nbits_legal(CfgNBits) ? CfgNBits : 4'(DEF_NBITS);
    assign ptr_next_s = (grant_id_q == IDW'(NUM_REQ-1)) ? '0 : grant_id_q + IDW'(1);

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q       <= IDLE;
            req_ready_q   <= '0;
            tx_en_q       <= 1'b0;
            tx_data_q     <= '0;
            nbits_q       <= 4'(DEF_NBITS);
            busy_q        <= 1'b0;
            grant_id_q    <= '0;
            timeout_err_q <= 1'b0;
            ptr_q         <= '0;
            wdog_q        <= '0;
        end else begin
            req_ready_q   <= '0;
            timeout_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|ReqValid) begin
                        req_ready_q <= pick_grant_s;
                        grant_id_q  <= pick_idx_s;
                        busy_q      <= 1'b1;
                        state_q     <= GRANT;
                    end
                end
                GRANT: begin
                    tx_data_q <= req_bytes_s[grant_id_q];
                    nbits_q   <= nbits_s;
                    wdog_q    <= '0;
                    tx_en_q   <= 1'b1;
                    state_q   <= SEND;
                end
                SEND: begin
                    // A completion in the same cycle as the final Tick is not an abort.
                    if (TxDone) begin
                        tx_en_q <= 1'b0;
                        state_q <= RELEASE;
                    end else if (Tick) begin
                        if (wdog_q == WDW'(TIMEOUT_TICKS-1)) begin
                            timeout_err_q <= 1'b1;
                            tx_en_q       <= 1'b0;
                            state_q       <= RELEASE;
                        end else begin
                            wdog_q <= wdog_q + WDW'(1);
                        end
                    end
                end
                RELEASE: begin
                    ptr_q   <= ptr_next_s;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    tx_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ReqReady   = req_ready_q;
    assign TxEn       = tx_en_q;
    assign TxData     = tx_data_q;
    assign NBits      = nbits_q;
    assign Busy       = busy_q;
    assign GrantId    = grant_id_q;
    assign TimeoutErr = timeout_err_q;

endmodule
